// File: rtl/text_renderer.sv
// -----------------------------------------------------------------------------
// text_renderer
//   Text-mode pixel generator. Turns the video timing generator's per-pixel
//   x/y/de/hs/vs into a 1-bit pixel stream. Each pixel follows this path:
//     - fetch the character code from an external text buffer,
//     - fetch the glyph bit from FontRom,
//     - apply inverse video and a blinking cursor.
//   The result is re-aligned with the syncs at a fixed 3-cycle latency.
//   Cells are 8x16 pixels and the font holds 128 glyphs.
//
// Ports
//   clk, reset              pixel clock; asynchronous active-high reset
//   in_de/in_hs/in_vs       timing inputs; in_vs rising edge marks a new frame
//   in_x, in_y              current pixel column / row
//   tb_addr, tb_re          text buffer read address / enable (combinational)
//   tb_data                 char code, one cycle after tb_addr; bit7 = inverse
//   font_ad                 FontRom address {code[6:0], glyph_row, glyph_col}
//   font_ce, font_oce       FontRom enables, always asserted
//   font_dout               glyph bit, one cycle after font_ad
//   cur_en, cur_block       cursor enable; 1 = full cell, 0 = underline
//   cur_col, cur_row        cursor cell position
//   out_de/out_hs/out_vs    timing delayed by 3 cycles
//   out_pix                 pixel, 1 = foreground
// -----------------------------------------------------------------------------
module text_renderer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int ADDR_W       = 12,
    parameter int BLINK_FRAMES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_de,
    input  logic              in_hs,
    input  logic              in_vs,
    input  logic [9:0]        in_x,
    input  logic [9:0]        in_y,
    output logic [ADDR_W-1:0] tb_addr,
    output logic              tb_re,
    input  logic [7:0]        tb_data,
    output logic [13:0]       font_ad,
    output logic              font_ce,
    output logic              font_oce,
    input  logic              font_dout,
    input  logic              cur_en,
    input  logic              cur_block,
    input  logic [6:0]        cur_col,
    input  logic [4:0]        cur_row,
    output logic              out_de,
    output logic              out_hs,
    output logic              out_vs,
    output logic              out_pix
);

    // Limits widened by one bit so the comparisons stay correct even when
    // COLS/ROWS equal the full range of the col/row fields.
    localparam logic [7:0] COLS_LIM = 8'(COLS);
    localparam logic [6:0] ROWS_LIM = 7'(ROWS);
    localparam logic [15:0] COLS_MUL = 16'(COLS);

    // The frame counter needs at least one bit even when BLINK_FRAMES is 1.
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    // ---------------- stage 0 (combinational on live inputs) ----------------
    logic [6:0]  col_s;
    logic [5:0]  row_s;
    logic        in_range_s;
    logic        hit_s;
    logic [15:0] addr_full_s;

    // Stage-0 decode: cell position, range test, buffer address and cursor hit.
    always_comb begin
        col_s       = in_x[9:3];
        row_s       = in_y[9:4];
        in_range_s  = ({1'b0, col_s} < COLS_LIM) && ({1'b0, row_s} < ROWS_LIM);
        addr_full_s = (16'(row_s) * COLS_MUL) + 16'(col_s);
        hit_s       = cur_en && (col_s == cur_col) && (row_s == {1'b0, cur_row});
    end

    assign tb_addr  = addr_full_s[ADDR_W-1:0];
    assign tb_re    = in_de & in_range_s;
    assign font_ce  = 1'b1;
    assign font_oce = 1'b1;

    // ---------------- stage 1 registers ----------------
    logic [2:0] x1_r;
    logic [3:0] y1_r;
    logic       vld1_r;
    logic       hit1_r;
    logic       blk1_r;
    logic       de1_r, hs1_r, vs1_r;

    // Stage-1 pipeline: glyph coordinates, visibility, cursor hit and syncs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x1_r   <= 3'd0;
            y1_r   <= 4'd0;
            vld1_r <= 1'b0;
            hit1_r <= 1'b0;
            blk1_r <= 1'b0;
            de1_r  <= 1'b0;
            hs1_r  <= 1'b0;
            vs1_r  <= 1'b0;
        end else begin
            x1_r   <= in_x[2:0];
            y1_r   <= in_y[3:0];
            vld1_r <= in_de & in_range_s;
            hit1_r <= hit_s;
            blk1_r <= cur_block;
            de1_r  <= in_de;
            hs1_r  <= in_hs;
            vs1_r  <= in_vs;
        end
    end

    // ---------------- blink generator ----------------
    logic             vs_prev_r;
    logic [CNT_W-1:0] frame_cnt_r;
    logic             blink_on_r;

    // Counts frames on in_vs rising edges and flips the cursor phase every
    // BLINK_FRAMES frames; independent of whether the cursor is enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_prev_r   <= 1'b0;
            frame_cnt_r <= {CNT_W{1'b0}};
            blink_on_r  <= 1'b1;
        end else begin
            vs_prev_r <= in_vs;
            if (in_vs && !vs_prev_r) begin
                if (frame_cnt_r == CNT_LAST) begin
                    frame_cnt_r <= {CNT_W{1'b0}};
                    blink_on_r  <= ~blink_on_r;
                end else begin
                    frame_cnt_r <= frame_cnt_r + 1'b1;
                end
            end
        end
    end

    // ---------------- stage 1 (combinational) ----------------
    logic curpix_s;

    // Underline cursor covers glyph rows 14 and 15 (y1[3:1] == 3'b111).
    always_comb begin
        curpix_s = hit1_r & blink_on_r & (blk1_r | (y1_r[3:1] == 3'b111));
    end

    assign font_ad = {tb_data[6:0], y1_r, x1_r};

    // ---------------- stage 2 registers ----------------
    logic inv2_r;
    logic blank2_r;
    logic curpix2_r;
    logic de2_r, hs2_r, vs2_r;

    // Stage-2 pipeline: inverse flag, blanking, cursor pixel and syncs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv2_r    <= 1'b0;
            blank2_r  <= 1'b1;
            curpix2_r <= 1'b0;
            de2_r     <= 1'b0;
            hs2_r     <= 1'b0;
            vs2_r     <= 1'b0;
        end else begin
            inv2_r    <= tb_data[7];
            blank2_r  <= ~vld1_r;
            curpix2_r <= curpix_s;
            de2_r     <= de1_r;
            hs2_r     <= hs1_r;
            vs2_r     <= vs1_r;
        end
    end

    // ---------------- stage 2 (combinational) ----------------
    logic pix_s;

    // Blanked pixels (outside the text area or de low) are forced to background.
    always_comb begin
        if (blank2_r) begin
            pix_s = 1'b0;
        end else begin
            pix_s = font_dout ^ inv2_r ^ curpix2_r;
        end
    end

    // Output registers: pixel and timing leave together after 3 cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_de  <= 1'b0;
            out_hs  <= 1'b0;
            out_vs  <= 1'b0;
            out_pix <= 1'b0;
        end else begin
            out_de  <= de2_r;
            out_hs  <= hs2_r;
            out_vs  <= vs2_r;
            out_pix <= pix_s;
        end
    end

endmodule
